dcache_mem_bridge: RTL and testbench
====================================

Name: dcache_mem_bridge

Overview:
- Sits directly downstream of the data cache and serves its block-miss requests against the 8-bit unified RAM port.
- Refill: fetches one BLOCK_SIZE-byte line byte-serially, then presents it as one wide word with a one-cycle valid pulse.
- Write-back: serializes a dirty line into BLOCK_SIZE single-byte RAM writes, then pulses an accept.
- Handles one transaction at a time. IO (mutable) accesses never pass through this block.

Parameters:
- BLOCK_WIDTH, 4, log2 of line size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes (16).

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  synchronous active-high reset.
- missIn  input  1  cache miss request; level signal, held until serviced.
- missAddrIn  input  [31:BLOCK_WIDTH]  line address of the request.
- readWriteIn  input  1  1 = refill (read RAM), 0 = write-back.
- writeBackIn  input  BLOCK_SIZE*8  dirty line data, byte i at bits [8i+7:8i].
- memDataValid  output  1  one-cycle pulse: memDataOut holds the refilled line.
- memAddr  output  [31:BLOCK_WIDTH]  line address of the current or just-finished transaction.
- memDataOut  output  BLOCK_SIZE*8  assembled refill line.
- acceptWrite  output  1  one-cycle pulse: write-back of memAddr is complete.
- ramDataIn  input  8  RAM read byte, valid one cycle after its address.
- ramDataOut  output  8  RAM write byte.
- ramAddrOut  output  32  RAM byte address.
- ramWrite  output  1  1 = write this cycle.
- ioBufferFull  input  1  RAM/IO write back-pressure.

Behaviour:
- One clock (clkIn). Reset is synchronous and active-high (resetIn). Both are fixed.
- Reset values: state IDLE, counters 0; memDataValid, acceptWrite, ramWrite = 0; ramAddrOut, ramDataOut, memAddr, memDataOut = 0.
- Reset mid-transaction: abandon it at the next edge; no valid or accept pulse is emitted.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - On the edge where missIn = 1, latch missAddrIn into memAddr and writeBackIn into the line buffer.
  - Clear issue counter and receive counter.
  - Go to READ if readWriteIn = 1, else WRITE.
  - All RAM outputs idle: ramWrite 0, ramAddrOut 0.
- READ:
  - Cycle k (k = 0..BLOCK_SIZE-1) drives ramAddrOut = {memAddr, k[BLOCK_WIDTH-1:0]} with ramWrite = 0.
  - The byte on ramDataIn in cycle k+1 is stored at line byte k.
  - The issue counter stops after BLOCK_SIZE-1. During the final receive cycle ramAddrOut holds the last address and ramWrite = 0.
  - After byte BLOCK_SIZE-1 is captured, memDataValid = 1 for exactly one cycle, with memDataOut = line and memAddr stable.
  - Latency: acceptance edge to the memDataValid cycle is BLOCK_SIZE+1 cycles (17).
  - Transition to DONE.
- WRITE:
  - Each cycle with ioBufferFull = 0: ramWrite = 1, ramAddrOut = {memAddr, k}, ramDataOut = line byte k; then k++.
  - Cycle with ioBufferFull = 1: ramWrite = 0, k holds, and the byte is re-presented later.
  - After byte BLOCK_SIZE-1 is written, the next cycle drives acceptWrite = 1 for one cycle (ramWrite = 0), then goes to DONE.
  - Latency with no stalls: acceptance edge to the acceptWrite cycle is 17 cycles.
- DONE:
  - One idle cycle with all pulses 0, so the cache can update dirty/valid and re-evaluate miss. Then IDLE.
  - missIn is ignored in DONE and in every non-IDLE state.
  - A miss still asserted in IDLE is accepted as a new transaction. This covers a write-back followed by a refill.
- Address arithmetic: byte addresses never cross the line. The low BLOCK_WIDTH bits come only from the counter and there is no carry into memAddr.
- memAddr and memDataOut hold their last values until the next acceptance; only the pulses return to 0.
- Never assert memDataValid and acceptWrite in the same cycle. Never assert ramWrite in READ, IDLE or DONE.

Decomposition:
- Shared package:
  - FSM state encoding (2 bits).
  - BLOCK_WIDTH/BLOCK_SIZE defaults, matching the cache.
  - Access-type and read/write select encodings (read = 1, write = 0).
  - IO region predicate constant (addr[17:16] == 2'b11).
- One natural sub-module: line_byte_buffer, a BLOCK_SIZE-byte register with byte-indexed write, byte-indexed read and full-width load/read.

Test Plan:
- Refill: reset, RAM preloaded with bytes 0x10..0x1F at 0x00000200. missIn = 1, readWriteIn = 1, missAddrIn = 0x0000020 → ramAddrOut sweeps 0x200..0x20F, ramWrite never 1. memDataValid pulses once 17 cycles after acceptance; memDataOut = 0x1F1E...1110; memAddr = 0x0000020.
- Write-back: writeBackIn = 0xFFEEDDCCBBAA99887766554433221100, missAddrIn = 0x0000100, readWriteIn = 0 → 16 writes to 0x1000..0x100F with bytes 0x00, 0x11, ..., 0xFF. acceptWrite pulses once on cycle 17; RAM contents match.
- Back-pressure: same write-back with ioBufferFull = 1 during the 3rd and 4th write cycles → byte 0x22 is held at 0x1002 with ramWrite 0 for 2 cycles. All 16 bytes are written once each; acceptWrite on cycle 19.
- Back-to-back: missIn held, write-back to line 0x0000100 then refill of line 0x0000020 → exactly one DONE gap cycle. Write completes (acceptWrite) before the first read address is issued.
- Reset mid-refill: resetIn = 1 at byte 7 of a refill → next cycle all outputs 0 and state IDLE, with no memDataValid. A fresh request afterwards completes normally in 17 cycles.
- Request during busy: missAddrIn changed to 0x0000300 mid-refill → ignored. memAddr stays 0x0000020 until DONE.

Source files
------------

// File: rtl/dcache_mem_bridge_pkg.sv
// Shared definitions for the data-cache to byte-wide RAM bridge: state encoding,
// line geometry defaults and access-type encodings.
package dcache_mem_bridge_pkg;

  localparam int DEF_BLOCK_WIDTH = 4;
  localparam int DEF_BLOCK_SIZE  = 2 ** DEF_BLOCK_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } bridgeState_e;

  typedef enum logic {
    ACCESS_CACHED = 1'b0,
    ACCESS_IO     = 1'b1
  } accessType_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Mutable IO space is decoded upstream; it never reaches this bridge.
  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic isIoAddr(input logic [31:0] addr);
    return (addr[17:16] == IO_REGION);
  endfunction

endpackage

// File: rtl/dcache_mem_bridge_line_byte_buffer.sv
// One cache line of storage: full-width load, byte-indexed write and read,
// and the whole line visible at all times.
module line_byte_buffer
  import dcache_mem_bridge_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    loadEn,
  input  logic [BLOCK_SIZE*8-1:0] loadData,
  input  logic                    wrEn,
  input  logic [BLOCK_WIDTH-1:0]  wrIdx,
  input  logic [7:0]              wrByte,
  input  logic [BLOCK_WIDTH-1:0]  rdIdx,
  output logic [7:0]              rdByte,
  output logic [BLOCK_SIZE*8-1:0] lineOut
);

  logic [BLOCK_SIZE*8-1:0] line_r;

  // Whole-line load wins over a single-byte update.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      line_r <= {(BLOCK_SIZE*8){1'b0}};
    end else if (loadEn) begin
      line_r <= loadData;
    end else if (wrEn) begin
      line_r[{wrIdx, 3'b000} +: 8] <= wrByte;
    end
  end

  assign rdByte  = line_r[{rdIdx, 3'b000} +: 8];
  assign lineOut = line_r;

endmodule

// File: rtl/dcache_mem_bridge.sv
// Serves data-cache line refills and write-backs over the 8-bit RAM port,
// one transaction at a time.
module dcache_mem_bridge
  import dcache_mem_bridge_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    missIn,
  input  logic [31:BLOCK_WIDTH]   missAddrIn,
  input  logic                    readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
  output logic                    memDataValid,
  output logic [31:BLOCK_WIDTH]   memAddr,
  output logic [BLOCK_SIZE*8-1:0] memDataOut,
  output logic                    acceptWrite,
  input  logic [7:0]              ramDataIn,
  output logic [7:0]              ramDataOut,
  output logic [31:0]             ramAddrOut,
  output logic                    ramWrite,
  input  logic                    ioBufferFull
);

  localparam int LINE_BITS = BLOCK_SIZE * 8;
  localparam logic [BLOCK_WIDTH-1:0] LAST_IDX = BLOCK_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [BLOCK_WIDTH-1:0] ONE_IDX  = BLOCK_WIDTH'(1);
  localparam logic [BLOCK_WIDTH-1:0] ZERO_IDX = BLOCK_WIDTH'(0);

  bridgeState_e state_r, state_s;
  logic [BLOCK_WIDTH-1:0] issueCnt_r, issueCnt_s, issueNext_s;
  logic [BLOCK_WIDTH-1:0] rxCnt_r, rxCnt_s, rxNext_s;
  logic rxPending_r, rxPending_s;
  logic wrArmed_r, wrArmed_s;
  logic memDataValid_r, memDataValid_s;
  logic acceptWrite_r, acceptWrite_s;
  logic [31:BLOCK_WIDTH] memAddr_r, memAddr_s;
  logic [LINE_BITS-1:0] memDataOut_r, memDataOut_s;
  logic [31:0] ramAddrOut_r, ramAddrOut_s;
  logic [7:0] ramDataOut_r, ramDataOut_s;
  logic bufLoad_s, bufWr_s;
  logic [BLOCK_WIDTH-1:0] bufRdIdx_s;
  logic [7:0] bufRdByte_s;
  logic [LINE_BITS-1:0] bufLine_s;

  assign issueNext_s = issueCnt_r + ONE_IDX;
  assign rxNext_s    = rxCnt_r + ONE_IDX;
  // Write-back pre-fetches the byte for the next cycle; the first byte comes from index 0.
  assign bufRdIdx_s  = wrArmed_r ? issueNext_s : issueCnt_r;

  line_byte_buffer #(
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) uLineBuf (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .loadEn  (bufLoad_s),
    .loadData(writeBackIn),
    .wrEn    (bufWr_s),
    .wrIdx   (rxCnt_r),
    .wrByte  (ramDataIn),
    .rdIdx   (bufRdIdx_s),
    .rdByte  (bufRdByte_s),
    .lineOut (bufLine_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_s        = state_r;
    issueCnt_s     = issueCnt_r;
    rxCnt_s        = rxCnt_r;
    rxPending_s    = rxPending_r;
    wrArmed_s      = wrArmed_r;
    memDataValid_s = 1'b0;
    acceptWrite_s  = 1'b0;
    memAddr_s      = memAddr_r;
    memDataOut_s   = memDataOut_r;
    ramAddrOut_s   = ramAddrOut_r;
    ramDataOut_s   = ramDataOut_r;
    bufLoad_s      = 1'b0;
    bufWr_s        = 1'b0;
    case (state_r)
      IDLE: begin
        ramAddrOut_s = 32'h0000_0000;
        ramDataOut_s = 8'h00;
        if (missIn) begin
          memAddr_s   = missAddrIn;
          bufLoad_s   = 1'b1;
          issueCnt_s  = ZERO_IDX;
          rxCnt_s     = ZERO_IDX;
          rxPending_s = 1'b0;
          wrArmed_s   = 1'b0;
          if (readWriteIn == RW_READ) begin
            state_s      = READ;
            ramAddrOut_s = {missAddrIn, ZERO_IDX};
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (memDataValid_r) begin
          state_s      = DONE;
          ramAddrOut_s = 32'h0000_0000;
        end else begin
          rxPending_s = 1'b1;
          if (issueCnt_r != LAST_IDX) begin
            issueCnt_s   = issueNext_s;
            ramAddrOut_s = {memAddr_r, issueNext_s};
          end else begin
            issueCnt_s = issueCnt_r;
          end
          // RAM answers one cycle after the address, so capture lags issue by one.
          if (rxPending_r) begin
            bufWr_s = 1'b1;
            rxCnt_s = rxNext_s;
            if (rxCnt_r == LAST_IDX) begin
              memDataValid_s = 1'b1;
              memDataOut_s   = {ramDataIn, bufLine_s[LINE_BITS-9:0]};
              rxPending_s    = 1'b0;
            end else begin
              memDataValid_s = 1'b0;
            end
          end else begin
            bufWr_s = 1'b0;
          end
        end
      end
      WRITE: begin
        if (acceptWrite_r) begin
          state_s = DONE;
        end else if (!wrArmed_r) begin
          wrArmed_s    = 1'b1;
          ramAddrOut_s = {memAddr_r, issueCnt_r};
          ramDataOut_s = bufRdByte_s;
        end else if (!ioBufferFull) begin
          if (issueCnt_r == LAST_IDX) begin
            wrArmed_s     = 1'b0;
            acceptWrite_s = 1'b1;
            ramAddrOut_s  = 32'h0000_0000;
            ramDataOut_s  = 8'h00;
          end else begin
            issueCnt_s   = issueNext_s;
            ramAddrOut_s = {memAddr_r, issueNext_s};
            ramDataOut_s = bufRdByte_s;
          end
        end else begin
          issueCnt_s = issueCnt_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s      = IDLE;
        ramAddrOut_s = 32'h0000_0000;
        ramDataOut_s = 8'h00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_r        <= IDLE;
      issueCnt_r     <= ZERO_IDX;
      rxCnt_r        <= ZERO_IDX;
      rxPending_r    <= 1'b0;
      wrArmed_r      <= 1'b0;
      memDataValid_r <= 1'b0;
      acceptWrite_r  <= 1'b0;
      memAddr_r      <= {(32-BLOCK_WIDTH){1'b0}};
      memDataOut_r   <= {LINE_BITS{1'b0}};
      ramAddrOut_r   <= 32'h0000_0000;
      ramDataOut_r   <= 8'h00;
    end else begin
      state_r        <= state_s;
      issueCnt_r     <= issueCnt_s;
      rxCnt_r        <= rxCnt_s;
      rxPending_r    <= rxPending_s;
      wrArmed_r      <= wrArmed_s;
      memDataValid_r <= memDataValid_s;
      acceptWrite_r  <= acceptWrite_s;
      memAddr_r      <= memAddr_s;
      memDataOut_r   <= memDataOut_s;
      ramAddrOut_r   <= ramAddrOut_s;
      ramDataOut_r   <= ramDataOut_s;
    end
  end

  // Back-pressure must suppress the strobe in the very cycle it is raised.
  assign ramWrite     = wrArmed_r & ~ioBufferFull;
  assign memDataValid = memDataValid_r;
  assign acceptWrite  = acceptWrite_r;
  assign memAddr      = memAddr_r;
  assign memDataOut   = memDataOut_r;
  assign ramAddrOut   = ramAddrOut_r;
  assign ramDataOut   = ramDataOut_r;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge with a small byte-RAM model.
module tb_dcache_mem_bridge;
  import dcache_mem_bridge_pkg::*;

  localparam logic [127:0] LINE_WB = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] LINE_RD = 128'h1F1E1D1C1B1A19181716151413121110;

  logic clk = 1'b0;
  logic resetIn, missIn, readWriteIn, ioBufferFull;
  logic [31:4] missAddrIn;
  logic [127:0] writeBackIn;
  logic memDataValid, acceptWrite, ramWrite;
  logic [31:4] memAddr;
  logic [127:0] memDataOut;
  logic [7:0] ramDataIn, ramDataOut;
  logic [31:0] ramAddrOut;

  int checks = 0;
  int errors = 0;

  logic [7:0] wrMem [16];
  int wrCount [16];
  int strayWrites;
  logic clrCounts = 1'b0;

  always #5 clk = ~clk;

  dcache_mem_bridge dut (
    .clkIn(clk), .resetIn(resetIn), .missIn(missIn), .missAddrIn(missAddrIn),
    .readWriteIn(readWriteIn), .writeBackIn(writeBackIn), .memDataValid(memDataValid),
    .memAddr(memAddr), .memDataOut(memDataOut), .acceptWrite(acceptWrite),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut), .ramAddrOut(ramAddrOut),
    .ramWrite(ramWrite), .ioBufferFull(ioBufferFull)
  );

  // RAM model: line 0x0000020 reads back 0x10..0x1F, writes to line 0x0000100 are recorded.
  always @(posedge clk) begin
    ramDataIn <= (ramAddrOut[31:4] == 28'h0000020) ? {4'h1, ramAddrOut[3:0]} : 8'hEE;
    if (clrCounts) begin
      for (int j = 0; j < 16; j++) begin
        wrCount[j] <= 0;
        wrMem[j]   <= 8'h00;
      end
      strayWrites <= 0;
    end else if (ramWrite) begin
      if (ramAddrOut[31:4] == 28'h0000100) begin
        wrMem[ramAddrOut[3:0]]   <= ramDataOut;
        wrCount[ramAddrOut[3:0]] <= wrCount[ramAddrOut[3:0]] + 1;
      end else begin
        strayWrites <= strayWrites + 1;
      end
    end
  end

  task automatic test_reset();
    resetIn = 1'b1; missIn = 1'b0; readWriteIn = 1'b0; ioBufferFull = 1'b0;
    missAddrIn = 28'h0; writeBackIn = 128'h0;
    repeat (3) @(posedge clk);
    #4;
    checks++; if (memDataValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", memDataValid); end
    checks++; if (acceptWrite !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b want 0", acceptWrite); end
    checks++; if (ramWrite !== 1'b0) begin errors++; $display("FAIL reset_ramWrite: got %b want 0", ramWrite); end
    checks++; if (ramAddrOut !== 32'h0) begin errors++; $display("FAIL reset_ramAddr: got %h want 0", ramAddrOut); end
    checks++; if (ramDataOut !== 8'h0) begin errors++; $display("FAIL reset_ramData: got %h want 0", ramDataOut); end
    checks++; if (memAddr !== 28'h0) begin errors++; $display("FAIL reset_memAddr: got %h want 0", memAddr); end
    checks++; if (memDataOut !== 128'h0) begin errors++; $display("FAIL reset_memData: got %h want 0", memDataOut); end
    @(posedge clk); #1; resetIn = 1'b0;
  endtask

  task automatic test_refill();
    int validCnt = 0;
    int validAt = -1;
    logic [31:0] expAddr;
    @(posedge clk); #1;
    missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = 28'h0000020;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      if (i == 0) missIn = 1'b0;
      #3;
      checks++; if (ramWrite !== 1'b0) begin errors++; $display("FAIL refill_ramWrite cyc %0d: got %b want 0", i, ramWrite); end
      if (i <= 16) begin
        expAddr = 32'h200 + 32'((i < 16) ? i : 15);
        checks++; if (ramAddrOut !== expAddr) begin errors++; $display("FAIL refill_addr cyc %0d: got %h want %h", i, ramAddrOut, expAddr); end
      end
      if (memDataValid === 1'b1) begin
        validCnt++; validAt = i;
        checks++; if (memDataOut !== LINE_RD) begin errors++; $display("FAIL refill_data: got %h want %h", memDataOut, LINE_RD); end
        checks++; if (memAddr !== 28'h0000020) begin errors++; $display("FAIL refill_memAddr: got %h want 0000020", memAddr); end
      end
    end
    checks++; if (validCnt != 1) begin errors++; $display("FAIL refill_pulses: got %0d want 1", validCnt); end
    checks++; if (validAt != 17) begin errors++; $display("FAIL refill_latency: got %0d want 17", validAt); end
    checks++; if (memDataOut !== LINE_RD) begin errors++; $display("FAIL refill_hold: got %h want %h", memDataOut, LINE_RD); end
  endtask

  task automatic test_writeback(input bit stall);
    int accCnt = 0;
    int accAt = -1;
    int k;
    int accExp;
    logic [7:0] expByte;
    accExp = stall ? 19 : 17;
    @(posedge clk); #1; clrCounts = 1'b1;
    @(posedge clk); #1; clrCounts = 1'b0;
    missIn = 1'b1; readWriteIn = 1'b0; missAddrIn = 28'h0000100; writeBackIn = LINE_WB;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (i == 0) missIn = 1'b0;
      ioBufferFull = stall && (i == 3 || i == 4);
      #3;
      if (stall && (i == 3 || i == 4)) begin
        checks++; if (ramWrite !== 1'b0) begin errors++; $display("FAIL bp_stall_write cyc %0d: got %b want 0", i, ramWrite); end
        checks++; if (ramAddrOut !== 32'h1002) begin errors++; $display("FAIL bp_stall_addr cyc %0d: got %h want 00001002", i, ramAddrOut); end
        checks++; if (ramDataOut !== 8'h22) begin errors++; $display("FAIL bp_stall_data cyc %0d: got %h want 22", i, ramDataOut); end
      end else begin
        k = (stall && i > 4) ? i - 3 : i - 1;
        if (i >= 1 && k < 16) begin
          expByte = 8'(k * 17);
          checks++; if (ramWrite !== 1'b1) begin errors++; $display("FAIL wb_write cyc %0d: got %b want 1", i, ramWrite); end
          checks++; if (ramAddrOut !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL wb_addr cyc %0d: got %h want %h", i, ramAddrOut, 32'h1000 + 32'(k)); end
          checks++; if (ramDataOut !== expByte) begin errors++; $display("FAIL wb_data cyc %0d: got %h want %h", i, ramDataOut, expByte); end
        end else begin
          checks++; if (ramWrite !== 1'b0) begin errors++; $display("FAIL wb_idle_write cyc %0d: got %b want 0", i, ramWrite); end
        end
      end
      checks++; if (memDataValid !== 1'b0) begin errors++; $display("FAIL wb_no_valid cyc %0d: got %b want 0", i, memDataValid); end
      if (acceptWrite === 1'b1) begin
        accCnt++; accAt = i;
        checks++; if (memAddr !== 28'h0000100) begin errors++; $display("FAIL wb_memAddr: got %h want 0000100", memAddr); end
      end
    end
    ioBufferFull = 1'b0;
    checks++; if (accCnt != 1) begin errors++; $display("FAIL wb_accept_pulses: got %0d want 1", accCnt); end
    checks++; if (accAt != accExp) begin errors++; $display("FAIL wb_latency: got %0d want %0d", accAt, accExp); end
    checks++; if (strayWrites != 0) begin errors++; $display("FAIL wb_stray: got %0d want 0", strayWrites); end
    for (int j = 0; j < 16; j++) begin
      expByte = 8'(j * 17);
      checks++; if (wrCount[j] != 1 || wrMem[j] !== expByte) begin
        errors++; $display("FAIL wb_ram byte %0d: got %h x%0d want %h x1", j, wrMem[j], wrCount[j], expByte);
      end
    end
  endtask

  task automatic test_backpressure();
    test_writeback(1'b1);
  endtask

  task automatic test_back_to_back();
    int accAt = -1;
    int firstRd = -1;
    int valAt = -1;
    int valCnt = 0;
    @(posedge clk); #1; clrCounts = 1'b1;
    @(posedge clk); #1; clrCounts = 1'b0;
    missIn = 1'b1; readWriteIn = 1'b0; missAddrIn = 28'h0000100; writeBackIn = LINE_WB;
    for (int i = 0; i < 41; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin readWriteIn = 1'b1; missAddrIn = 28'h0000020; end
      if (i == 38) missIn = 1'b0;
      #3;
      if (acceptWrite === 1'b1 && accAt < 0) accAt = i;
      if (ramAddrOut === 32'h200 && firstRd < 0) firstRd = i;
      if (memDataValid === 1'b1) begin
        valCnt++; valAt = i;
        checks++; if (memDataOut !== LINE_RD || memAddr !== 28'h0000020) begin
          errors++; $display("FAIL b2b_refill: got %h @%h want %h @0000020", memDataOut, memAddr, LINE_RD);
        end
      end
      if (i == 18 || i == 19) begin
        checks++; if (ramAddrOut !== 32'h0 || ramWrite !== 1'b0 || memDataValid !== 1'b0 || acceptWrite !== 1'b0) begin
          errors++; $display("FAIL b2b_gap cyc %0d: got addr %h wr %b v %b a %b want all 0", i, ramAddrOut, ramWrite, memDataValid, acceptWrite);
        end
      end
    end
    checks++; if (accAt != 17) begin errors++; $display("FAIL b2b_accept: got %0d want 17", accAt); end
    checks++; if (firstRd != 20) begin errors++; $display("FAIL b2b_first_read: got %0d want 20", firstRd); end
    checks++; if (valCnt != 1 || valAt != 37) begin errors++; $display("FAIL b2b_valid: got %0d pulses at %0d want 1 at 37", valCnt, valAt); end
    checks++; if (strayWrites != 0) begin errors++; $display("FAIL b2b_stray: got %0d want 0", strayWrites); end
  endtask

  task automatic test_reset_mid_refill();
    int valAt = -1;
    @(posedge clk); #1;
    missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = 28'h0000020;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 0) missIn = 1'b0;
      if (i == 7) resetIn = 1'b1;
      if (i == 8) resetIn = 1'b0;
      #3;
      if (i == 7) begin
        checks++; if (ramAddrOut !== 32'h207) begin errors++; $display("FAIL rst_pre_addr: got %h want 00000207", ramAddrOut); end
      end
      if (i == 8) begin
        checks++; if (ramAddrOut !== 32'h0 || ramDataOut !== 8'h0 || ramWrite !== 1'b0) begin
          errors++; $display("FAIL rst_ram_outputs: got %h %h %b want 0 0 0", ramAddrOut, ramDataOut, ramWrite);
        end
        checks++; if (memAddr !== 28'h0 || memDataOut !== 128'h0 || acceptWrite !== 1'b0) begin
          errors++; $display("FAIL rst_mem_outputs: got %h %h %b want 0 0 0", memAddr, memDataOut, acceptWrite);
        end
      end
      checks++; if (memDataValid !== 1'b0) begin errors++; $display("FAIL rst_no_valid cyc %0d: got %b want 0", i, memDataValid); end
    end
    @(posedge clk); #1;
    missIn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) missIn = 1'b0;
      #3;
      if (memDataValid === 1'b1 && valAt < 0) begin
        valAt = i;
        checks++; if (memDataOut !== LINE_RD) begin errors++; $display("FAIL rst_fresh_data: got %h want %h", memDataOut, LINE_RD); end
      end
    end
    checks++; if (valAt != 17) begin errors++; $display("FAIL rst_fresh_latency: got %0d want 17", valAt); end
  endtask

  task automatic test_busy_request();
    int valAt = -1;
    @(posedge clk); #1;
    missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = 28'h0000020;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      if (i == 5) missAddrIn = 28'h0000300;
      if (i == 17) missIn = 1'b0;
      #3;
      if (i <= 18) begin
        checks++; if (memAddr !== 28'h0000020) begin errors++; $display("FAIL busy_memAddr cyc %0d: got %h want 0000020", i, memAddr); end
      end
      if (i <= 16) begin
        checks++; if (ramAddrOut[31:4] !== 28'h0000020) begin errors++; $display("FAIL busy_ramAddr cyc %0d: got %h want line 0000020", i, ramAddrOut); end
      end
      if (memDataValid === 1'b1 && valAt < 0) valAt = i;
    end
    checks++; if (valAt != 17) begin errors++; $display("FAIL busy_latency: got %0d want 17", valAt); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback(1'b0);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_refill();
    test_busy_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
